vga_fb_reader: RTL and testbench

VGA_FB_READER -- requirements
Module: vga_fb_reader

---
 rtl/vga_fb_reader.sv | 117 +++++++++++
 tb/tb_vga_fb_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// Framebuffer reader: fetches pixel bursts from memory into a FIFO and hands
// RGB565 words to the VGA driver on request, restarting at address 0 each frame.
module vga_fb_reader #(
  parameter int FIFO_DEPTH  = 64,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 19
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          data_req,
  output logic [15:0]                   data,
  input  logic                          v_sync,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rd_ack,
  input  logic                          rd_valid,
  input  logic [15:0]                   rd_data,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [LW-1:0] REQ_THRESH = LW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, FLUSH} state_t;
  state_t state, state_nxt;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr_cnt;
  logic [BW-1:0]     beat_cnt;
  logic              v_sync_p1, flush_pend;
  logic              frame_start, fifo_empty, pop, push, last_beat, ack_live, in_burst;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] nxt;
    nxt = {1'b0, a} + (ADDR_W+1)'(BURST_LEN);
    if (nxt >= (ADDR_W+1)'(FRAME_WORDS)) return '0;
    return nxt[ADDR_W-1:0];
  endfunction

  assign frame_start = v_sync_p1 & ~v_sync;
  assign fifo_empty  = (fifo_level == '0);
  assign pop         = data_req & ~fifo_empty;
  assign in_burst    = (state == RECV) | (state == FLUSH);
  assign push        = rd_valid & (state == RECV) & (fifo_level != FULL_LVL);
  assign last_beat   = rd_valid & in_burst & (beat_cnt == LAST_BEAT);
  // A burst already flagged for flushing must not move the address away from 0.
  assign ack_live    = (state == REQ) & rd_ack & ~flush_pend & ~frame_start;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!frame_start && fifo_level <= REQ_THRESH) state_nxt = REQ;
      REQ:     if (rd_ack) state_nxt = (flush_pend | frame_start) ? FLUSH : RECV;
      RECV:    if (last_beat) state_nxt = IDLE;
               else if (frame_start) state_nxt = FLUSH;
      FLUSH:   if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_req = (state == REQ);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      v_sync_p1  <= 1'b1;
      flush_pend <= 1'b0;
      rd_addr    <= '0;
      addr_cnt   <= '0;
      beat_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      data       <= '0;
      underflow  <= 1'b0;
    end else begin
      v_sync_p1 <= v_sync;
      if (state != REQ || rd_ack) flush_pend <= 1'b0;
      else if (frame_start)       flush_pend <= 1'b1;
      if (state == IDLE && state_nxt == REQ) rd_addr <= addr_cnt;
      if (frame_start)   addr_cnt <= '0;
      else if (ack_live) addr_cnt <= step_addr(addr_cnt);
      if (rd_valid && in_burst) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
      // Pop reads the pre-flush head even when the FIFO is emptied this cycle.
      if (data_req) data <= fifo_empty ? 16'h0000 : mem[rd_ptr];
      if (frame_start) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        underflow  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        fifo_level <= fifo_level + LW'(push) - LW'(pop);
        if (data_req && fifo_empty) underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push && !frame_start) mem[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Scoreboard bench for vga_fb_reader: memory model, queue-based reference
// model of the pixel stream, and a monitor that checks each served pixel.
module tb_vga_fb_reader;
  localparam int FD = 64, BL = 16, FW = 64, AW = 19;

  logic          sys_clk = 1'b0, rst = 1'b0, data_req = 1'b0, v_sync = 1'b1;
  logic          rd_ack = 1'b0, rd_valid = 1'b0;
  logic [15:0]   rd_data = '0;
  logic [15:0]   data;
  logic          rd_req, underflow;
  logic [AW-1:0] rd_addr;
  logic [6:0]    fifo_level;

  vga_fb_reader #(.FIFO_DEPTH(FD), .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .rst(rst), .data_req(data_req), .data(data), .v_sync(v_sync),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .underflow(underflow), .fifo_level(fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0, n_pass = 0;
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // stimulus controls
  bit drv_req = 0, drv_vs = 1, drv_rst = 0, mem_stall = 0, valid_always = 1;
  // inputs applied during the current cycle, and outputs observed in it
  bit c_req, c_vs, c_ack, c_valid, c_rst;
  bit o_rd_req = 0, o_rd_req_prev = 0;
  int o_rd_addr = 0, o_level = 0;
  // reference model
  int model_q[$];
  int sb[$];
  int starts[$];
  int model_addr = 0, burst_base = 0, beat_no = 0;
  bit model_uf = 0, vs_prev = 1, burst_out = 0, burst_live = 0;
  // memory model
  typedef enum int {M_IDLE, M_ACK, M_BEAT} mst_t;
  mst_t mst = M_IDLE;
  int mem_base = 0, mem_idx = 0;
  bit req_d = 0;

  task automatic drive_inputs();
    rst = drv_rst;
    v_sync = drv_vs;
    rd_ack = 1'b0;
    rd_valid = 1'b0;
    rd_data = 16'($urandom);
    if (drv_rst) begin
      data_req = 1'b0;
      mst = M_IDLE;
      sb.delete();
      req_d = 0;
      #1;
      check("rst_data", longint'(data), 0);
      check("rst_rd_req", longint'(rd_req), 0);
      check("rst_rd_addr", longint'(rd_addr), 0);
      check("rst_underflow", longint'(underflow), 0);
      check("rst_fifo_level", longint'(fifo_level), 0);
    end else begin
      data_req = drv_req;
      case (mst)
        M_IDLE: if (o_rd_req && !mem_stall) mst = M_ACK;
        M_ACK: begin
          rd_ack = 1'b1;
          mem_base = o_rd_addr;
          mem_idx = 0;
          mst = M_BEAT;
        end
        M_BEAT: if (valid_always || $urandom_range(3) != 0) begin
          rd_valid = 1'b1;
          rd_data = 16'(mem_base + mem_idx);
          mem_idx++;
          if (mem_idx == BL) mst = M_IDLE;
        end
        default: mst = M_IDLE;
      endcase
    end
    c_req = data_req; c_vs = v_sync; c_ack = rd_ack; c_valid = rd_valid; c_rst = rst;
  endtask

  task automatic process_edge();
    bit fs;
    if (c_rst) begin
      model_q.delete(); sb.delete();
      model_addr = 0; model_uf = 0; vs_prev = 1;
      burst_out = 0; burst_live = 0; beat_no = 0;
      return;
    end
    fs = vs_prev && !c_vs;
    vs_prev = c_vs;
    if (c_req) begin
      if (model_q.size() > 0) sb.push_back(model_q.pop_front());
      else begin sb.push_back(0); model_uf = 1; end
    end
    if (c_valid && burst_out) begin
      if (burst_live && !fs) begin
        check("no_push_when_full", longint'(o_level < FD), 1);
        model_q.push_back(burst_base + beat_no);
      end
      beat_no++;
      if (beat_no == BL) burst_out = 0;
    end
    if (c_ack && burst_live && !fs) model_addr = (model_addr + BL) % FW;
    if (fs) begin
      model_q.delete();
      model_addr = 0;
      model_uf = 0;
      burst_live = 0;
    end
  endtask

  task automatic sample_check();
    o_rd_req_prev = o_rd_req;
    o_rd_req = rd_req;
    o_rd_addr = int'(rd_addr);
    o_level = int'(fifo_level);
    check("fifo_level", longint'(fifo_level), longint'(model_q.size()));
    check("underflow", longint'(underflow), longint'(model_uf));
    if (o_rd_req && !o_rd_req_prev) begin
      starts.push_back(o_rd_addr);
      check("rd_addr", longint'(o_rd_addr), longint'(model_addr));
      burst_out = 1; burst_live = 1; burst_base = model_addr; beat_no = 0;
    end
  endtask

  task automatic cycle();
    drive_inputs();
    @(posedge sys_clk);
    #1;
    process_edge();
    sample_check();
  endtask

  task automatic pulse_vs();
    drv_vs = 0; cycle();
    drv_vs = 1; cycle();
  endtask

  always @(posedge sys_clk) req_d = data_req && !rst;

  always @(negedge sys_clk) begin
    if (req_d) begin
      if (sb.size() == 0) check("sb_has_entry", 0, 1);
      else check("data", longint'(data), longint'(sb.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n, prev;
    #2;
    drv_rst = 1; repeat (3) cycle();
    drv_rst = 0;

    // initial fill: four bursts, then quiet
    repeat (150) cycle();
    check("burst_count", longint'(starts.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < starts.size()) check("burst_addr", longint'(starts[i]), longint'(i * BL));
    check("full_level", longint'(fifo_level), FD);

    // read 20 pixels, one refill at the wrapped address
    drv_req = 1; repeat (20) cycle(); drv_req = 0;
    repeat (60) cycle();
    check("refill_count", longint'(starts.size()), 5);
    if (starts.size() >= 5) check("wrap_addr", longint'(starts[4]), 0);

    // empty FIFO with stalled memory
    mem_stall = 1;
    pulse_vs();
    repeat (3) cycle();
    drv_req = 1; cycle(); drv_req = 0; cycle();
    check("underflow_set", longint'(underflow), 1);
    repeat (10) cycle();
    check("underflow_held", longint'(underflow), 1);
    pulse_vs();
    check("underflow_cleared", longint'(underflow), 0);
    mem_stall = 0;
    for (int i = 0; i < 100 && burst_out; i++) cycle();
    check("flush_done", longint'(burst_out), 0);
    check("flush_level", longint'(fifo_level), 0);

    // frame start after 5 beats of a live burst
    for (int i = 0; i < 100 && !(burst_live && beat_no == 5); i++) cycle();
    check("reached_5_beats", longint'(burst_live && beat_no == 5), 1);
    drv_vs = 0; cycle(); drv_vs = 1;
    for (int i = 0; i < 100 && burst_out; i++) cycle();
    check("discard_level", longint'(fifo_level), 0);
    n = starts.size();
    for (int i = 0; i < 20 && starts.size() == n; i++) cycle();
    check("restart_req", longint'(starts.size()), longint'(n + 1));
    if (starts.size() > n) check("restart_addr", longint'(starts[n]), 0);

    // reset mid-burst
    for (int i = 0; i < 100 && !(burst_live && beat_no == 3); i++) cycle();
    check("reached_3_beats", longint'(burst_live && beat_no == 3), 1);
    drv_rst = 1; cycle(); drv_rst = 0;
    n = starts.size();
    for (int i = 0; i < 20 && starts.size() == n; i++) cycle();
    check("post_rst_req", longint'(starts.size()), longint'(n + 1));
    if (starts.size() > n) check("post_rst_addr", longint'(starts[n]), 0);
    repeat (100) cycle();
    drv_req = 1; repeat (5) cycle(); drv_req = 0;
    repeat (40) cycle();

    // continuous reads while memory keeps pace
    drv_req = 1;
    for (int i = 0; i < 120; i++) begin
      prev = int'(fifo_level);
      cycle();
      if (c_req && c_valid && burst_live && prev > 0 && prev < FD)
        check("pushpop_level", longint'(fifo_level), longint'(prev));
    end
    drv_req = 0;
    check("no_underflow", longint'(underflow), 0);

    // randomized traffic
    valid_always = 0;
    for (int i = 0; i < 3000; i++) begin
      drv_req = 1'($urandom_range(1));
      mem_stall = ($urandom_range(3) == 0);
      drv_vs = ($urandom_range(150) != 0);
      drv_rst = ($urandom_range(999) == 0);
      cycle();
    end
    drv_req = 0; drv_rst = 0; drv_vs = 1;
    repeat (3) cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
